// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer with registered handshakes and a saturating stall counter
module pipe_skid_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DATA_WIDTH-1:0] reset_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state, state_nx;
    logic [DATA_WIDTH-1:0] main_nx, skid, skid_nx;
    logic in_hs, out_hs;
    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;
    // next state and register contents; flush overrides any handshake outcome
    always_comb begin
        state_nx = state;
        main_nx  = out_data;
        skid_nx  = skid;
        case (state)
            EMPTY: if (in_hs) begin
                main_nx  = in_data;
                state_nx = ONE;
            end
            ONE: if (in_hs && out_hs) main_nx = in_data;
                 else if (in_hs) begin
                     skid_nx  = in_data;
                     state_nx = TWO;
                 end
                 else if (out_hs) state_nx = EMPTY;
            TWO: if (out_hs) begin
                main_nx  = skid;
                state_nx = ONE;
            end
            default: state_nx = EMPTY;
        endcase
        if (flush) begin
            state_nx = EMPTY;
            main_nx  = reset_data;
        end
    end
    // state, payload and handshake flags; flags are decoded from the next state so they stay registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_data  <= reset_data;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            stall_cnt <= '0;
        end else begin
            state     <= state_nx;
            out_data  <= main_nx;
            out_valid <= state_nx != EMPTY;
            in_ready  <= state_nx != TWO;
            if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
    // skid contents are meaningless while empty, so they need no reset
    always_ff @(posedge clk) skid <= skid_nx;
endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and randomized checks of pipe_skid_reg against a queue model
module tb_pipe_skid_reg;
    logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [7:0] in_data = 0, reset_data = 0;
    logic in_ready, out_valid, in_ready4, out_valid4;
    logic [7:0] out_data, out_data4;
    logic [15:0] stall_cnt;
    logic [3:0] stall_cnt4;
    int tests_run = 0, fails = 0;
    logic [7:0] q[$];
    logic [7:0] md;
    int c16 = 0, c4 = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .reset_data(reset_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .stall_cnt(stall_cnt)
    );

    pipe_skid_reg #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .reset_data(reset_data), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .stall_cnt(stall_cnt4)
    );

    // one clock edge: advance the reference model with the inputs present at the edge, then settle at negedge
    task automatic tick();
        bit ov, ir;
        @(posedge clk);
        ov = q.size() > 0;
        ir = q.size() < 2;
        if (rst) begin
            q.delete();
            md = reset_data;
            c16 = 0;
            c4 = 0;
        end else begin
            if (ov && !out_ready) begin
                c16 = (c16 < 65535) ? c16 + 1 : c16;
                c4  = (c4 < 15) ? c4 + 1 : c4;
            end
            if (flush) begin
                q.delete();
                md = reset_data;
            end else begin
                if (ov && out_ready) void'(q.pop_front());
                if (in_valid && ir) q.push_back(in_data);
                if (q.size() > 0) md = q[0];
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; reset_data = 8'hA5; flush = 0; in_valid = 0; out_ready = 0;
        tick(); tick();
        tests_run++;
        if (out_data !== 8'hA5 || out_valid !== 1'b0 || in_ready !== 1'b1 || stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
            fails++;
            $display("FAIL reset: out_data=%h out_valid=%b in_ready=%b stall=%0d stall4=%0d, want a5 0 1 0 0",
                     out_data, out_valid, in_ready, stall_cnt, stall_cnt4);
        end
        rst = 0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1; in_data = 8'(i);
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 8'(i) || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b beat %0d: out_valid=%b out_data=%h in_ready=%b, want 1 %h 1", i, out_valid, out_data, in_ready, 8'(i));
            end
        end
        in_valid = 0;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b drain: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_skid();
        out_ready = 0; in_valid = 1; in_data = 8'h11;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL skid first: out_valid=%b out_data=%h in_ready=%b, want 1 11 1", out_valid, out_data, in_ready);
        end
        in_data = 8'h22;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h11 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL skid full: out_valid=%b out_data=%h in_ready=%b, want 1 11 0", out_valid, out_data, in_ready);
        end
        in_valid = 0; in_data = 8'hEE; out_ready = 1;
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h22 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL skid drain1: out_valid=%b out_data=%h in_ready=%b, want 1 22 1", out_valid, out_data, in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL skid drain2: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        out_ready = 0; in_valid = 1; in_data = 8'h44;
        tick();
        in_data = 8'h55;
        tick();
        reset_data = 8'h5A; flush = 1; in_data = 8'h33;
        tick();
        flush = 0; in_valid = 0;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 8'h5A || in_ready !== 1'b1 || stall_cnt !== 16'(c16)) begin
            fails++;
            $display("FAIL flush: out_valid=%b out_data=%h in_ready=%b stall=%0d, want 0 5a 1 %0d", out_valid, out_data, in_ready, stall_cnt, c16);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b0 || out_data !== 8'h5A) begin
                fails++;
                $display("FAIL flush after %0d: out_valid=%b out_data=%h, want 0 5a", i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_stall_sat();
        rst = 1; out_ready = 0; in_valid = 0;
        tick();
        rst = 0; in_valid = 1; in_data = 8'h77;
        tick();
        in_valid = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            tests_run++;
            if (stall_cnt4 !== 4'(k < 15 ? k : 15) || stall_cnt !== 16'(k) || out_data !== 8'h77 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL stall k=%0d: stall4=%0d stall=%0d out_data=%h out_valid=%b, want %0d %0d 77 1",
                         k, stall_cnt4, stall_cnt, out_data, out_valid, k < 15 ? k : 15, k);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1; in_data = 8'h88;
        tick();
        in_data = 8'h99;
        tick();
        rst = 1; flush = 1; out_ready = 1; reset_data = 8'hC3; in_data = 8'h12;
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'hC3 || stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0) begin
            fails++;
            $display("FAIL reset mid: out_valid=%b in_ready=%b out_data=%h stall=%0d stall4=%0d, want 0 1 c3 0 0",
                     out_valid, in_ready, out_data, stall_cnt, stall_cnt4);
        end
        rst = 0; flush = 0; out_ready = 0; in_data = 8'h66;
        tick();
        in_valid = 0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'h66) begin
            fails++;
            $display("FAIL reset first beat: out_valid=%b out_data=%h, want 1 66", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        logic [7:0] send_seq, rcv_seq, prev_data;
        bit prev_stalled;
        int received;
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        tick();
        rst = 0; send_seq = 0; rcv_seq = 0; received = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom % 3) != 0;
            out_ready = ($urandom % 2) != 0;
            in_data   = send_seq;
            reset_data = 8'($urandom);
            if (out_valid && out_ready) begin
                tests_run++;
                if (out_data !== rcv_seq) begin
                    fails++;
                    $display("FAIL rand order cyc%0d: out_data=%h, want %h", c, out_data, rcv_seq);
                end
                rcv_seq++;
                received++;
            end
            if (in_valid && q.size() < 2) send_seq++;
            prev_stalled = out_valid && !out_ready;
            prev_data = out_data;
            tick();
            tests_run++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || out_data !== md ||
                stall_cnt !== 16'(c16) || stall_cnt4 !== 4'(c4) || (prev_stalled && out_data !== prev_data)) begin
                fails++;
                $display("FAIL rand cyc%0d: out_valid=%b/%b in_ready=%b/%b out_data=%h/%h stall=%0d/%0d stall4=%0d/%0d held=%h (got/want)",
                         c, out_valid, q.size() > 0, in_ready, q.size() < 2, out_data, md, stall_cnt, c16, stall_cnt4, c4, prev_data);
            end
        end
        in_valid = 0;
        tests_run++;
        if (received < 2000) begin
            fails++;
            $display("FAIL rand progress: received=%0d, want >= 2000", received);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_skid();
        test_flush();
        test_stall_sat();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
